// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes resolved in MEM, whole-pipeline freeze on data-memory busy, and saturating event counters.
module pipeline_hazard_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             counters_clear,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             memwb_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } stateT;

  stateT curState;
  logic  loadUse;
  logic  fireFreeze;
  logic  fireFlush;
  logic  fireStall;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + CNT_W'(1);
  endfunction

  assign loadUse = idex_mem_read && (idex_rd != 5'd0) &&
                   ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  // Priority: busy freeze > taken branch > load-use; the load-use check is
  // masked for the one cycle spent in STALL so each hazard yields one bubble.
  assign fireFreeze = !reset && mem_busy;
  assign fireFlush  = !reset && !mem_busy && branch_taken;
  assign fireStall  = !reset && !mem_busy && !branch_taken && loadUse && (curState != STALL);

  assign pc_hold     = fireFreeze || fireStall;
  assign ifid_hold   = fireFreeze || fireStall;
  assign idex_hold   = fireFreeze;
  assign exmem_hold  = fireFreeze;
  assign memwb_hold  = fireFreeze;
  assign ifid_flush  = fireFlush;
  assign idex_bubble = fireFlush || fireStall;
  assign exmem_flush = fireFlush;
  assign state       = curState;

  always_ff @(posedge clk) begin
    if (reset) begin
      curState <= RUN;
    end else if (fireFreeze) begin
      curState <= FREEZE;
    end else if (fireStall) begin
      curState <= STALL;
    end else begin
      curState <= RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || counters_clear) begin
      stall_count  <= '0;
      flush_count  <= '0;
      freeze_count <= '0;
    end else begin
      if (fireStall)  stall_count  <= satInc(stall_count);
      if (fireFlush)  flush_count  <= satInc(flush_count);
      if (fireFreeze) freeze_count <= satInc(freeze_count);
    end
  end

endmodule
